// File: rtl/banner_scroll_ctrl.sv
// Rotating-banner sequencer: scroll-step timebase, message start index, run/stop and wrap dwell.
// Optional ping-pong mode is enabled by defining BANNER_SCROLL_BOUNCE_EN.
module banner_scroll_ctrl #(
  parameter int MSG_LEN     = 10,
  parameter int IDX_W       = 4,
  parameter int TICK_DIV    = 50000000,
  parameter int DIV_W       = 26,
  parameter int DWELL_STEPS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             stop,
  input  logic             dir,
  output logic [IDX_W-1:0] index,
  output logic             step,
  output logic             wrapped,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DWELL} state_t;

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(MSG_LEN - 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [3:0]       DWELL_LAST = 4'((DWELL_STEPS > 0) ? DWELL_STEPS - 1 : 0);
  localparam bit               DWELL_EN   = (DWELL_STEPS > 0);

  // Wrap is explicit at MSG_LEN, never at 2^IDX_W.
  function automatic logic [IDX_W-1:0] idx_up(input logic [IDX_W-1:0] i);
    return (i == IDX_LAST) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [IDX_W-1:0] idx_dn(input logic [IDX_W-1:0] i);
    return (i == '0) ? IDX_LAST : i - 1'b1;
  endfunction

  state_t           state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [3:0]       dwell_q, dwell_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             tick;
  logic             up;
  logic             at_end;

`ifdef BANNER_SCROLL_BOUNCE_EN
  logic dir_q, dir_d;
  assign up = ~dir_q;
`else
  assign up = ~dir;
`endif

  assign tick   = (state_q != IDLE) && (presc_q == DIV_LAST);
  assign at_end = up ? (index_q == IDX_LAST) : (index_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      index_q <= '0;
      presc_q <= '0;
      dwell_q <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
`ifdef BANNER_SCROLL_BOUNCE_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      presc_q <= presc_d;
      dwell_q <= dwell_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
`ifdef BANNER_SCROLL_BOUNCE_EN
      dir_q   <= dir_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    dwell_d = dwell_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
`ifdef BANNER_SCROLL_BOUNCE_EN
    dir_d   = dir_q;
`endif
    unique case (state_q)
      IDLE: begin
        presc_d = '0;
        dwell_d = '0;
        if (go && !stop) begin
          state_d = RUN;
`ifdef BANNER_SCROLL_BOUNCE_EN
          dir_d   = dir;
`endif
        end
      end
      RUN: begin
        if (tick) begin
          step_d = 1'b1;
          wrap_d = at_end;
`ifdef BANNER_SCROLL_BOUNCE_EN
          if (at_end) begin
            index_d = up ? IDX_LAST - 1'b1 : IDX_W'(1);
            dir_d   = ~dir_q;
          end else begin
            index_d = up ? idx_up(index_q) : idx_dn(index_q);
          end
`else
          index_d = up ? idx_up(index_q) : idx_dn(index_q);
`endif
          if (at_end && DWELL_EN) begin
            state_d = DWELL;
            dwell_d = '0;
          end
        end
      end
      DWELL: begin
        if (tick) begin
          dwell_d = dwell_q + 1'b1;
          if (dwell_q == DWELL_LAST) state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    // stop overrides everything, including a step landing on this edge.
    if (stop && state_q != IDLE) begin
      state_d = IDLE;
      index_d = index_q;
      presc_d = '0;
      dwell_d = '0;
      step_d  = 1'b0;
      wrap_d  = 1'b0;
`ifdef BANNER_SCROLL_BOUNCE_EN
      dir_d   = dir_q;
`endif
    end
  end

  assign index   = index_q;
  assign step    = step_q;
  assign wrapped = wrap_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_banner_scroll_ctrl.sv
// Scoreboard bench for banner_scroll_ctrl: expected steps are queued ahead and checked as they appear.
module tb_banner_scroll_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       go, stop, dir;
  logic [2:0] index;
  logic       step, wrapped, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int at_edge;
    int idx;
    int w;
  } exp_t;
  exp_t sb[$];

  banner_scroll_ctrl #(
    .MSG_LEN(5), .IDX_W(3), .TICK_DIV(4), .DIV_W(2), .DWELL_STEPS(2)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .stop(stop), .dir(dir),
    .index(index), .step(step), .wrapped(wrapped), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic exp_step(input int e, input int idx, input int w);
    exp_t x;
    x.at_edge = e;
    x.idx     = idx;
    x.w       = w;
    sb.push_back(x);
  endtask

  // Returns 1 time unit after edge number e.
  task automatic wait_to(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Step monitor: pops the scoreboard on every step pulse.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (sb.size() > 0 && sb[0].at_edge < cyc) begin
        chk("missed_step", cyc, sb[0].at_edge);
        void'(sb.pop_front());
      end
      if (step) begin
        if (sb.size() == 0) begin
          chk("unexpected_step", int'(index), -1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("step_edge", cyc, e.at_edge);
          chk("step_index", int'(index), e.idx);
          chk("step_wrapped", int'(wrapped), e.w);
        end
      end else if (wrapped) begin
        chk("wrapped_without_step", int'(wrapped), 0);
      end
    end
  end

  initial begin
    int g, t, h;
    reset = 1'b1;
    go    = 1'b0;
    stop  = 1'b0;
    dir   = 1'b0;
    wait_to(2);
    chk("rst_index", int'(index), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_step", int'(step), 0);
    chk("rst_wrapped", int'(wrapped), 0);
    reset = 1'b0;
    g = cyc + 3;

    wait_to(g - 1);
    dir = 1'b0;
    go  = 1'b1;
`ifdef BANNER_SCROLL_BOUNCE_EN
    exp_step(g + 4, 1, 0);
    exp_step(g + 8, 2, 0);
    exp_step(g + 12, 3, 0);
    exp_step(g + 16, 4, 0);
    exp_step(g + 20, 3, 1);
    exp_step(g + 32, 2, 0);
    exp_step(g + 36, 1, 0);
    exp_step(g + 40, 0, 0);
    exp_step(g + 44, 1, 1);
    exp_step(g + 56, 2, 0);
    t = g + 60;
    wait_to(g);
    go = 1'b0;
    chk("busy_after_go", int'(busy), 1);
    chk("index_after_go", int'(index), 0);
    wait_to(g + 5);
    dir = 1'b1;
    wait_to(g + 28);
    chk("dwell_hold_index", int'(index), 3);
    chk("dwell_busy", int'(busy), 1);
    dir = 1'b0;
`else
    exp_step(g + 4, 1, 0);
    exp_step(g + 8, 2, 0);
    exp_step(g + 12, 3, 0);
    exp_step(g + 16, 4, 0);
    exp_step(g + 20, 0, 1);
    exp_step(g + 32, 1, 0);
    exp_step(g + 36, 0, 0);
    exp_step(g + 40, 4, 1);
    exp_step(g + 52, 3, 0);
    exp_step(g + 56, 4, 0);
    exp_step(g + 60, 3, 0);
    exp_step(g + 64, 2, 0);
    t = g + 68;
    wait_to(g);
    go = 1'b0;
    chk("busy_after_go", int'(busy), 1);
    chk("index_after_go", int'(index), 0);
    wait_to(g + 28);
    chk("dwell_hold_index", int'(index), 0);
    chk("dwell_busy", int'(busy), 1);
    wait_to(g + 32);
    dir = 1'b1;
    wait_to(g + 54);
    dir = 1'b0;
    wait_to(g + 56);
    dir = 1'b1;
`endif

    // stop lands on a tick edge with index 2
    wait_to(t - 1);
    stop = 1'b1;
    wait_to(t);
    stop = 1'b0;
    chk("stop_index", int'(index), 2);
    chk("stop_busy", int'(busy), 0);
    chk("stop_step", int'(step), 0);
    chk("stop_wrapped", int'(wrapped), 0);

    wait_to(t + 2);
    go   = 1'b1;
    stop = 1'b1;
    wait_to(t + 4);
    chk("go_stop_idle_busy", int'(busy), 0);
    chk("go_stop_idle_index", int'(index), 2);
    go   = 1'b0;
    stop = 1'b0;

    h = t + 7;
    wait_to(h - 1);
    dir = 1'b0;
    go  = 1'b1;
    exp_step(h + 4, 3, 0);
    wait_to(h);
    go = 1'b0;
    chk("restart_busy", int'(busy), 1);
    wait_to(h + 1);
    go = 1'b1;
    wait_to(h + 3);
    go = 1'b0;

    // asynchronous reset while step is high at index 3
    wait_to(h + 4);
    chk("pre_reset_index", int'(index), 3);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_index", int'(index), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_step", int'(step), 0);
    chk("async_rst_wrapped", int'(wrapped), 0);
    #10;
    reset = 1'b0;
    chk("scoreboard_drained", sb.size(), 0);
    wait_to(cyc + 6);
    chk("idle_after_reset_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
